// File: rtl/cart_loader_if.sv
// ============================================================================
//  Module   : cart_loader_if
//  Brief    : Download-side and ROM-store-side signal bundle for cart_loader.
//             The slave modport is the loader; the master modport is whatever
//             feeds the download and consumes the ROM store writes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface cart_loader_if #(
    parameter int MEM_AW = 17
);
    // download source side
    logic              DL_START;
    logic              DL_END;
    logic [7:0]        DL_DATA;
    logic              DL_VALID;
    logic              DL_READY;
    // ROM store / cartridge side
    logic [MEM_AW-1:0] INIT_ADDR;
    logic [7:0]        INIT_DATA;
    logic              INIT_VALID;
    logic [4:0]        CFG_AW;
    logic              CART_READY;
    logic              OVERFLOW;

    modport master (
        output DL_START, DL_END, DL_DATA, DL_VALID,
        input  DL_READY, INIT_ADDR, INIT_DATA, INIT_VALID,
               CFG_AW, CART_READY, OVERFLOW
    );

    modport slave (
        input  DL_START, DL_END, DL_DATA, DL_VALID,
        output DL_READY, INIT_ADDR, INIT_DATA, INIT_VALID,
               CFG_AW, CART_READY, OVERFLOW
    );
endinterface

`default_nettype wire

// File: rtl/cart_loader.sv
// ============================================================================
//  Module   : cart_loader
//  Brief    : Streams a downloaded cartridge image into the ROM store, one
//             write per accepted byte, then derives the cartridge address
//             mask width from the image size and flags the cartridge ready.
//             Bytes beyond the store depth are dropped and flagged sticky.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cart_loader #(
    parameter int MEM_AW     = 17,
    parameter int CFG_AW_MIN = 10,
    parameter int CFG_AW_MAX = 15
) (
    input  wire logic     CLK,
    input  wire logic     RESB,
    cart_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [5:0] c_cfg_min = 6'(CFG_AW_MIN);
    localparam logic [5:0] c_cfg_max = 6'(CFG_AW_MAX);

    state_t            r_state;
    // one extra bit so a completely full store (2^MEM_AW bytes) is representable
    logic [MEM_AW:0]   r_count;
    logic [MEM_AW-1:0] r_init_addr;
    logic [7:0]        r_init_data;
    logic              r_init_valid;
    logic [4:0]        r_cfg_aw;
    logic              r_cart_ready;
    logic              r_overflow;

    logic [MEM_AW:0]   w_count_m1;
    logic [5:0]        w_clog2;
    logic [4:0]        w_cfg_next;

    // ceil(log2(count)) is the bit length of (count-1); clamp into range,
    // with counts 0 and 1 pinned to the minimum width
    always_comb begin
        w_count_m1 = r_count - {{MEM_AW{1'b0}}, 1'b1};
        w_clog2    = 6'd0;
        for (int i = 0; i <= MEM_AW; i++) begin
            if (w_count_m1[i]) begin
                w_clog2 = 6'(i + 1);
            end
        end
        w_cfg_next = c_cfg_min[4:0];
        if (r_count[MEM_AW:1] == '0) begin
            w_cfg_next = c_cfg_min[4:0];
        end else if (w_clog2 < c_cfg_min) begin
            w_cfg_next = c_cfg_min[4:0];
        end else if (w_clog2 > c_cfg_max) begin
            w_cfg_next = c_cfg_max[4:0];
        end else begin
            w_cfg_next = w_clog2[4:0];
        end
    end

    // download state machine with registered store-side outputs;
    // DL_START restarts from any state and overrides DL_END
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_init_addr  <= '0;
            r_init_data  <= 8'h00;
            r_init_valid <= 1'b0;
            r_cfg_aw     <= c_cfg_max[4:0];
            r_cart_ready <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_init_valid <= 1'b0;
            if (bus.DL_START) begin
                r_state      <= LOAD;
                r_count      <= '0;
                r_overflow   <= 1'b0;
                r_cart_ready <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    LOAD: begin
                        if (bus.DL_VALID) begin
                            if (!r_count[MEM_AW]) begin
                                r_init_valid <= 1'b1;
                                r_init_addr  <= r_count[MEM_AW-1:0];
                                r_init_data  <= bus.DL_DATA;
                                r_count      <= r_count + {{MEM_AW{1'b0}}, 1'b1};
                            end else begin
                                // store full: keep accepting so the source never stalls
                                r_overflow <= 1'b1;
                            end
                        end
                        if (bus.DL_END) begin
                            r_state <= FINISH;
                        end
                    end
                    FINISH: begin
                        r_cfg_aw     <= w_cfg_next;
                        r_cart_ready <= 1'b1;
                        r_state      <= DONE;
                    end
                    DONE: begin
                        r_state <= DONE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.DL_READY   = (r_state == LOAD);
    assign bus.INIT_ADDR  = r_init_addr;
    assign bus.INIT_DATA  = r_init_data;
    assign bus.INIT_VALID = r_init_valid;
    assign bus.CFG_AW     = r_cfg_aw;
    assign bus.CART_READY = r_cart_ready;
    assign bus.OVERFLOW   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_cart_loader.sv
// ============================================================================
//  Module   : tb_cart_loader
//  Brief    : Directed self-checking bench for cart_loader. The store depth is
//             scaled to 2^14 bytes and the maximum width to 13 so that the
//             full-store, clamp and overflow cases fit a short run.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cart_loader;

    localparam int TB_AW  = 14;
    localparam int DEPTH  = 1 << TB_AW;
    localparam int AW_MIN = 10;
    localparam int AW_MAX = 13;

    logic CLK;
    logic RESB;
    int   checks;
    int   errors;

    cart_loader_if #(.MEM_AW(TB_AW)) bus ();

    cart_loader #(
        .MEM_AW     (TB_AW),
        .CFG_AW_MIN (AW_MIN),
        .CFG_AW_MAX (AW_MAX)
    ) dut (
        .CLK  (CLK),
        .RESB (RESB),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_pulse();
        bus.DL_START = 1'b1;
        tick();
        bus.DL_START = 1'b0;
    endtask

    // streams n back-to-back bytes; DL_END optionally rides on the last byte
    task automatic run_stream(input int n, input bit end_on_last,
                              output int wr_cnt, output int wr_bad,
                              output int rdy_bad, output int cr_bad);
        wr_cnt = 0; wr_bad = 0; rdy_bad = 0; cr_bad = 0;
        for (int i = 0; i < n; i++) begin
            bus.DL_VALID = 1'b1;
            bus.DL_DATA  = pat(i);
            bus.DL_END   = end_on_last && (i == n - 1);
            if (bus.DL_READY !== 1'b1) rdy_bad++;
            tick();
            if (bus.CART_READY !== 1'b0) cr_bad++;
            if (i < DEPTH) begin
                if (bus.INIT_VALID !== 1'b1 || bus.INIT_ADDR !== TB_AW'(i) ||
                    bus.INIT_DATA !== pat(i)) wr_bad++;
            end else if (bus.INIT_VALID !== 1'b0) begin
                wr_bad++;
            end
            if (bus.INIT_VALID === 1'b1) wr_cnt++;
        end
        bus.DL_VALID = 1'b0;
        bus.DL_END   = 1'b0;
    endtask

    task automatic test_reset();
        RESB = 1'b1;
        #3;
        RESB = 1'b0;
        #1;
        checks++; if (bus.DL_READY !== 1'b0) begin errors++; $display("FAIL rst_dl_ready got %b want 0", bus.DL_READY); end
        checks++; if (bus.INIT_VALID !== 1'b0) begin errors++; $display("FAIL rst_init_valid got %b want 0", bus.INIT_VALID); end
        checks++; if (bus.INIT_ADDR !== '0) begin errors++; $display("FAIL rst_init_addr got %h want 0", bus.INIT_ADDR); end
        checks++; if (bus.INIT_DATA !== 8'h00) begin errors++; $display("FAIL rst_init_data got %h want 00", bus.INIT_DATA); end
        checks++; if (bus.CFG_AW !== 5'd13) begin errors++; $display("FAIL rst_cfg_aw got %0d want 13", bus.CFG_AW); end
        checks++; if (bus.CART_READY !== 1'b0) begin errors++; $display("FAIL rst_cart_ready got %b want 0", bus.CART_READY); end
        checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", bus.OVERFLOW); end
        tick();
        tick();
        RESB = 1'b1;
        tick();
        checks++; if (bus.DL_READY !== 1'b0) begin errors++; $display("FAIL idle_dl_ready got %b want 0", bus.DL_READY); end
    endtask

    task automatic test_load_8192();
        int wc, wb, rb, cb;
        start_pulse();
        checks++; if (bus.DL_READY !== 1'b1) begin errors++; $display("FAIL l8k_ready_after_start got %b want 1", bus.DL_READY); end
        run_stream(8192, 1'b1, wc, wb, rb, cb);
        checks++; if (wb !== 0) begin errors++; $display("FAIL l8k_writes bad beats %0d want 0", wb); end
        checks++; if (wc !== 8192) begin errors++; $display("FAIL l8k_write_count got %0d want 8192", wc); end
        checks++; if (rb !== 0 || cb !== 0) begin errors++; $display("FAIL l8k_ready_flags dl_ready drops %0d cart_ready highs %0d want 0/0", rb, cb); end
        checks++; if (bus.INIT_ADDR !== 14'h1FFF) begin errors++; $display("FAIL l8k_last_addr got %h want 1fff", bus.INIT_ADDR); end
        // now in FINISH: one cycle after DL_END, not ready yet
        checks++; if (bus.CART_READY !== 1'b0) begin errors++; $display("FAIL l8k_finish_cart_ready got %b want 0", bus.CART_READY); end
        checks++; if (bus.CFG_AW !== 5'd13) begin errors++; $display("FAIL l8k_cfg_hold got %0d want 13", bus.CFG_AW); end
        tick();
        checks++; if (bus.CART_READY !== 1'b1) begin errors++; $display("FAIL l8k_cart_ready got %b want 1", bus.CART_READY); end
        checks++; if (bus.CFG_AW !== 5'd13) begin errors++; $display("FAIL l8k_cfg_aw got %0d want 13", bus.CFG_AW); end
        checks++; if (bus.OVERFLOW !== 1'b0 || bus.DL_READY !== 1'b0) begin errors++; $display("FAIL l8k_done_flags overflow %b dl_ready %b want 0/0", bus.OVERFLOW, bus.DL_READY); end
        // DL_END in DONE is ignored
        bus.DL_END = 1'b1;
        tick();
        bus.DL_END = 1'b0;
        tick();
        checks++; if (bus.CART_READY !== 1'b1 || bus.INIT_VALID !== 1'b0) begin errors++; $display("FAIL done_end_ignored cart_ready %b init_valid %b want 1/0", bus.CART_READY, bus.INIT_VALID); end
    endtask

    task automatic test_sizes();
        int wc, wb, rb, cb;
        // 5000 bytes -> width 13
        start_pulse();
        checks++; if (bus.CART_READY !== 1'b0) begin errors++; $display("FAIL s5000_start_clears got %b want 0", bus.CART_READY); end
        run_stream(5000, 1'b1, wc, wb, rb, cb);
        tick();
        checks++; if (wb !== 0 || wc !== 5000) begin errors++; $display("FAIL s5000_writes bad %0d count %0d want 0/5000", wb, wc); end
        checks++; if (bus.CFG_AW !== 5'd13 || bus.CART_READY !== 1'b1) begin errors++; $display("FAIL s5000_cfg got %0d ready %b want 13/1", bus.CFG_AW, bus.CART_READY); end
        // 1 byte -> minimum width
        start_pulse();
        run_stream(1, 1'b1, wc, wb, rb, cb);
        checks++; if (wb !== 0 || wc !== 1) begin errors++; $display("FAIL s1_writes bad %0d count %0d want 0/1", wb, wc); end
        tick();
        checks++; if (bus.CFG_AW !== 5'd10 || bus.CART_READY !== 1'b1) begin errors++; $display("FAIL s1_cfg got %0d ready %b want 10/1", bus.CFG_AW, bus.CART_READY); end
        // 0 bytes -> minimum width, no write strobes
        start_pulse();
        bus.DL_END = 1'b1;
        tick();
        bus.DL_END = 1'b0;
        checks++; if (bus.INIT_VALID !== 1'b0 || bus.CART_READY !== 1'b0) begin errors++; $display("FAIL s0_finish init_valid %b ready %b want 0/0", bus.INIT_VALID, bus.CART_READY); end
        tick();
        checks++; if (bus.INIT_VALID !== 1'b0) begin errors++; $display("FAIL s0_no_write got %b want 0", bus.INIT_VALID); end
        checks++; if (bus.CFG_AW !== 5'd10 || bus.CART_READY !== 1'b1) begin errors++; $display("FAIL s0_cfg got %0d ready %b want 10/1", bus.CFG_AW, bus.CART_READY); end
    endtask

    task automatic test_full_store();
        int wc, wb, rb, cb;
        start_pulse();
        run_stream(DEPTH, 1'b1, wc, wb, rb, cb);
        tick();
        checks++; if (wb !== 0 || wc !== DEPTH) begin errors++; $display("FAIL full_writes bad %0d count %0d want 0/%0d", wb, wc, DEPTH); end
        checks++; if (bus.INIT_ADDR !== 14'h3FFF) begin errors++; $display("FAIL full_last_addr got %h want 3fff", bus.INIT_ADDR); end
        // ceil(log2(16384)) = 14, clamped to 13
        checks++; if (bus.CFG_AW !== 5'd13) begin errors++; $display("FAIL full_cfg_clamp got %0d want 13", bus.CFG_AW); end
        checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL full_overflow got %b want 0", bus.OVERFLOW); end
    endtask

    task automatic test_overflow();
        int wc, wb, rb, cb;
        start_pulse();
        run_stream(DEPTH + 1, 1'b1, wc, wb, rb, cb);
        checks++; if (wb !== 0 || wc !== DEPTH) begin errors++; $display("FAIL ovf_writes bad %0d count %0d want 0/%0d", wb, wc, DEPTH); end
        checks++; if (rb !== 0) begin errors++; $display("FAIL ovf_dl_ready drops %0d want 0", rb); end
        checks++; if (bus.INIT_ADDR !== 14'h3FFF || bus.INIT_DATA !== pat(DEPTH - 1)) begin errors++; $display("FAIL ovf_last_write addr %h data %h want 3fff/%h", bus.INIT_ADDR, bus.INIT_DATA, pat(DEPTH - 1)); end
        checks++; if (bus.OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.OVERFLOW); end
        tick();
        checks++; if (bus.OVERFLOW !== 1'b1 || bus.CFG_AW !== 5'd13 || bus.CART_READY !== 1'b1) begin errors++; $display("FAIL ovf_done overflow %b cfg %0d ready %b want 1/13/1", bus.OVERFLOW, bus.CFG_AW, bus.CART_READY); end
        start_pulse();
        checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_cleared_by_start got %b want 0", bus.OVERFLOW); end
    endtask

    task automatic test_restart();
        int wc, wb, rb, cb;
        run_stream(100, 1'b0, wc, wb, rb, cb);
        checks++; if (wb !== 0 || cb !== 0) begin errors++; $display("FAIL rs_first_pass bad %0d cart_ready highs %0d want 0/0", wb, cb); end
        start_pulse();
        checks++; if (bus.CART_READY !== 1'b0 || bus.DL_READY !== 1'b1) begin errors++; $display("FAIL rs_restart ready %b dl_ready %b want 0/1", bus.CART_READY, bus.DL_READY); end
        // second pass must begin writing at address 0 again
        run_stream(2048, 1'b1, wc, wb, rb, cb);
        checks++; if (wb !== 0 || wc !== 2048 || cb !== 0) begin errors++; $display("FAIL rs_second_pass bad %0d count %0d cart_ready highs %0d want 0/2048/0", wb, wc, cb); end
        tick();
        checks++; if (bus.CFG_AW !== 5'd11 || bus.CART_READY !== 1'b1) begin errors++; $display("FAIL rs_cfg got %0d ready %b want 11/1", bus.CFG_AW, bus.CART_READY); end
    endtask

    task automatic test_reset_mid_load();
        int wc, wb, rb, cb;
        start_pulse();
        run_stream(50, 1'b0, wc, wb, rb, cb);
        bus.DL_VALID = 1'b1;
        bus.DL_DATA  = 8'h3C;
        #2;
        RESB = 1'b0;
        #1;
        checks++; if (bus.DL_READY !== 1'b0 || bus.INIT_VALID !== 1'b0) begin errors++; $display("FAIL mid_rst_now dl_ready %b init_valid %b want 0/0", bus.DL_READY, bus.INIT_VALID); end
        checks++; if (bus.CFG_AW !== 5'd13) begin errors++; $display("FAIL mid_rst_cfg got %0d want 13", bus.CFG_AW); end
        tick();
        checks++; if (bus.INIT_VALID !== 1'b0 || bus.INIT_ADDR !== '0) begin errors++; $display("FAIL mid_rst_held init_valid %b addr %h want 0/0", bus.INIT_VALID, bus.INIT_ADDR); end
        RESB = 1'b1;
        bus.DL_VALID = 1'b0;
        tick();
        bus.DL_END = 1'b1;
        tick();
        bus.DL_END = 1'b0;
        tick();
        tick();
        checks++; if (bus.CART_READY !== 1'b0 || bus.DL_READY !== 1'b0 || bus.INIT_VALID !== 1'b0) begin errors++; $display("FAIL mid_rst_end_ignored ready %b dl_ready %b init_valid %b want 0/0/0", bus.CART_READY, bus.DL_READY, bus.INIT_VALID); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        bus.DL_START = 1'b0;
        bus.DL_END   = 1'b0;
        bus.DL_DATA  = 8'h00;
        bus.DL_VALID = 1'b0;
        test_reset();
        test_load_8192();
        test_sizes();
        test_full_store();
        test_overflow();
        test_restart();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
